rally_judge: RTL and testbench
==============================

Name: rally_judge

Overview:
- Upstream stage of the score block. Runs one ping-pong rally on an LED lane, with a ball that steps between two paddle buttons.
- Decides who won each point and emits a clean goal pulse with a stable current_player, which the score block consumes.
- Reads finish back from the score block to enter the game-over state.

Parameters:
- LANE_LEN, 8, number of ball positions (LEDs); minimum 2.
- TICK_DIV, 25000000, clk cycles per ball step; minimum 2.
- GOAL_CYCLES, 4, width of the goal pulse in clk cycles; minimum 1.

Ports:
- clk  input  1  system clock.
- total_reset  input  1  asynchronous, active-high reset.
- btn1  input  1  player-1 paddle, raw and asynchronous.
- btn2  input  1  player-2 paddle, raw and asynchronous.
- finish  input  2  from score: 0 = none, 1 = player 1 won, 2 = player 2 won.
- ball_pos  output  LANE_LEN  one-hot ball LED. Bit 0 is the player-1 end; bit LANE_LEN-1 is the player-2 end.
- goal  output  1  point-awarded pulse to score.
- current_player  output  4  point scorer: 0 = player 1, 1 = player 2. Never takes other values.
- serving  output  1  high while waiting for a serve.

Behaviour:
- Reset (async, total_reset=1): state SERVE_WAIT, server = P1, pos = 0, goal = 0, current_player = 0, divider = 0, sync/edge flops = 0.
  - Outputs: ball_pos = 1, serving = 1.
  - Reset mid-rally or mid-goal-pulse aborts immediately. goal drops asynchronously.
- Buttons: each passes a 2-flop synchroniser plus a rising-edge detector. Input to edge output is 3 cycles. Only edges act; a held button acts once.
- Divider: counts 0..TICK_DIV-1 only in MOVE_R/MOVE_L. It clears on entry to either state, including the direction reversal on a hit. tick = wrap.
- States:
  - SERVE_WAIT:
    - pos = 0 if server is P1, pos = LANE_LEN-1 if server is P2.
    - The server's edge moves to MOVE_R (P1) or MOVE_L (P2). Pos is unchanged until the first tick.
    - The other player's edge is ignored.
  - MOVE_R:
    - On tick with pos < LANE_LEN-1: pos+1.
    - btn2 edge with pos == LANE_LEN-1: hit, go to MOVE_L.
    - On tick with pos == LANE_LEN-1 and no hit: miss, P1 scores, go to GOAL.
    - btn2 edge with pos < LANE_LEN-1: foul, P1 scores, go to GOAL.
    - btn1 edges are ignored.
  - MOVE_L: mirror image of MOVE_R.
    - pos-1 on tick; end position is 0; receiver is btn1.
    - Miss or foul means P2 scores.
    - btn2 edges are ignored.
  - Hit and tick in the same cycle: the hit wins.
  - GOAL:
    - Cycle 0: current_player is loaded; goal stays 0 (setup).
    - Cycles 1..GOAL_CYCLES: goal = 1.
    - Then 2 cycles with goal = 0 (SETTLE, finish propagates). Then sample finish.
    - If finish != 0, go to OVER. Otherwise go to SERVE_WAIT with server = loser of the point.
    - ball_pos holds its last value. All button edges are ignored.
    - current_player holds its value until the next GOAL entry.
  - OVER:
    - ball_pos is all ones; serving = 0.
    - Any button edge goes to SERVE_WAIT with server = P1 and pos = 0.
- goal is registered and glitch-free. It is high only in GOAL pulse cycles.
- Width: pos is $clog2(LANE_LEN) bits. ball_pos = 1 << pos. pos never leaves 0..LANE_LEN-1.

Decomposition:
- Shared package (game_pkg):
  - state enum: SERVE_WAIT, MOVE_R, MOVE_L, GOAL, SETTLE, OVER.
  - PLAYER1 = 4'd0, PLAYER2 = 4'd1.
  - FINISH_NONE / FINISH_P1 / FINISH_P2 = 2'd0 / 1 / 2.
- One sub-module: btn_sync_edge (2-flop synchroniser plus rising-edge pulse), instantiated twice.

Test Plan (LANE_LEN=4, TICK_DIV=3, GOAL_CYCLES=2; score model attached):
- Reset, then btn1 press → ball_pos steps 0001→0010→0100→1000, one step every 3 cycles. With no btn2, the next tick gives GOAL: current_player = 0, goal high 2 cycles, then SERVE_WAIT with ball_pos = 1000 (P2 serves).
- Ball reaches 1000, btn2 pressed → MOVE_L, divider restarts, ball_pos 0100 after 3 cycles. Simultaneous btn1 edge does nothing.
- btn2 pressed while ball_pos = 0010 in MOVE_R → foul: current_player = 0, one goal pulse.
- btn2 held high through 5 ticks → acts once only. A hit at the end tick gives MOVE_L, not a point.
- 5 consecutive P1 points → finish = 1 sampled, OVER with ball_pos = 1111. Any press gives SERVE_WAIT, ball_pos = 0001.
- Assert total_reset during goal high → goal = 0 immediately, ball_pos = 0001, current_player = 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the rally judge and its score block.
package game_pkg;

   typedef enum logic [2:0] {
      SERVE_WAIT,
      MOVE_R,
      MOVE_L,
      GOAL,
      SETTLE,
      OVER
   } state_t;

   localparam logic [3:0] PLAYER1 = 4'd0;
   localparam logic [3:0] PLAYER2 = 4'd1;

   localparam logic [1:0] FINISH_NONE = 2'd0;
   localparam logic [1:0] FINISH_P1   = 2'd1;
   localparam logic [1:0] FINISH_P2   = 2'd2;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for a raw paddle button followed by a registered
// rising-edge detector; pulse rises three clocks after the button does.
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta  <= 1'b0;
         sync  <= 1'b0;
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         meta  <= btn;
         sync  <= meta;
         prev  <= sync;
         pulse <= sync & ~prev;
      end
   end

endmodule

// File: rtl/rally_judge.sv
// Ping-pong rally referee: moves the ball along the LED lane, judges hits,
// misses and fouls, and hands a clean goal pulse plus scorer to the score block.
module rally_judge
   import game_pkg::*;
#(
   parameter int LANE_LEN    = 8,
   parameter int TICK_DIV    = 25000000,
   parameter int GOAL_CYCLES = 4
) (
   input  logic                clk,
   input  logic                total_reset,
   input  logic                btn1,
   input  logic                btn2,
   input  logic [1:0]          finish,
   output logic [LANE_LEN-1:0] ball_pos,
   output logic                goal,
   output logic [3:0]          current_player,
   output logic                serving
);

   localparam int PW = $clog2(LANE_LEN);
   localparam int DW = $clog2(TICK_DIV);
   localparam int CW = $clog2(GOAL_CYCLES + 1);

   localparam logic [PW-1:0] POS_LAST    = PW'(LANE_LEN - 1);
   localparam logic [DW-1:0] DIV_LAST    = DW'(TICK_DIV - 1);
   localparam logic [CW-1:0] PULSE_LAST  = CW'(GOAL_CYCLES);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(1);

   state_t          state, state_n;
   logic [PW-1:0]   pos, pos_n;
   logic            server_p2, server_p2_n;
   logic [DW-1:0]   div, div_n;
   logic [CW-1:0]   phase, phase_n;
   logic [3:0]      scorer, scorer_n;
   logic            goal_n;
   logic            e1, e2;
   logic            tick;
   logic            moving_n;

   btn_sync_edge u_btn1 (.clk(clk), .rst(total_reset), .btn(btn1), .pulse(e1));
   btn_sync_edge u_btn2 (.clk(clk), .rst(total_reset), .btn(btn2), .pulse(e2));

   always_ff @(posedge clk or posedge total_reset) begin
      if (total_reset) begin
         state     <= SERVE_WAIT;
         pos       <= '0;
         server_p2 <= 1'b0;
         div       <= '0;
         phase     <= '0;
         scorer    <= PLAYER1;
         goal      <= 1'b0;
      end else begin
         state     <= state_n;
         pos       <= pos_n;
         server_p2 <= server_p2_n;
         div       <= div_n;
         phase     <= phase_n;
         scorer    <= scorer_n;
         goal      <= goal_n;
      end
   end

   always_comb begin
      state_n     = state;
      pos_n       = pos;
      server_p2_n = server_p2;
      phase_n     = phase;
      scorer_n    = scorer;
      tick        = (state == MOVE_R || state == MOVE_L) && (div == DIV_LAST);

      case (state)
         SERVE_WAIT: begin
            if (!server_p2 && e1)
               state_n = MOVE_R;
            else if (server_p2 && e2)
               state_n = MOVE_L;
         end
         // A hit at the far end takes priority over a coincident tick.
         MOVE_R: begin
            if (e2 && pos == POS_LAST) begin
               state_n = MOVE_L;
            end else if (e2 || (tick && pos == POS_LAST)) begin
               state_n  = GOAL;
               scorer_n = PLAYER1;
               phase_n  = '0;
            end else if (tick) begin
               pos_n = pos + PW'(1);
            end
         end
         MOVE_L: begin
            if (e1 && pos == '0) begin
               state_n = MOVE_R;
            end else if (e1 || (tick && pos == '0)) begin
               state_n  = GOAL;
               scorer_n = PLAYER2;
               phase_n  = '0;
            end else if (tick) begin
               pos_n = pos - PW'(1);
            end
         end
         GOAL: begin
            if (phase == PULSE_LAST) begin
               state_n = SETTLE;
               phase_n = '0;
            end else begin
               phase_n = phase + CW'(1);
            end
         end
         SETTLE: begin
            if (phase == SETTLE_LAST) begin
               if (finish != FINISH_NONE) begin
                  state_n = OVER;
               end else begin
                  state_n     = SERVE_WAIT;
                  server_p2_n = (scorer == PLAYER1);
                  pos_n       = (scorer == PLAYER1) ? POS_LAST : '0;
               end
            end else begin
               phase_n = phase + CW'(1);
            end
         end
         OVER: begin
            if (e1 || e2) begin
               state_n     = SERVE_WAIT;
               server_p2_n = 1'b0;
               pos_n       = '0;
            end
         end
         default: state_n = SERVE_WAIT;
      endcase

      // Divider restarts whenever a move state is (re)entered, including reversal.
      moving_n = (state_n == MOVE_R) || (state_n == MOVE_L);
      div_n    = (moving_n && state_n == state && !tick) ? div + DW'(1) : '0;
      goal_n   = (state_n == GOAL) && (phase_n != '0);
   end

   assign ball_pos       = (state == OVER) ? '1 : (LANE_LEN'(1) << pos);
   assign serving        = (state == SERVE_WAIT);
   assign current_player = scorer;

endmodule

// File: tb/tb_rally_judge.sv
// Directed bench for rally_judge with a rule-level reference model and a
// small score block closing the finish loop.
module tb_rally_judge;

   localparam int LL = 4;
   localparam int TD = 3;
   localparam int GC = 2;

   localparam int MD_SERVE = 0;
   localparam int MD_RIGHT = 1;
   localparam int MD_LEFT  = 2;
   localparam int MD_POINT = 3;
   localparam int MD_OVER  = 4;

   logic          clk = 1'b0;
   logic          total_reset = 1'b1;
   logic          btn1 = 1'b0;
   logic          btn2 = 1'b0;
   logic [1:0]    finish = 2'd0;
   logic [LL-1:0] ball_pos;
   logic          goal;
   logic [3:0]    current_player;
   logic          serving;

   rally_judge #(
      .LANE_LEN(LL),
      .TICK_DIV(TD),
      .GOAL_CYCLES(GC)
   ) dut (
      .clk(clk),
      .total_reset(total_reset),
      .btn1(btn1),
      .btn2(btn2),
      .finish(finish),
      .ball_pos(ball_pos),
      .goal(goal),
      .current_player(current_player),
      .serving(serving)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_mode, m_pos, m_server, m_timer, m_age, m_cp;
   bit h1[5];
   bit h2[5];

   task automatic model_reset();
      m_mode = MD_SERVE; m_pos = 0; m_server = 0; m_timer = 0; m_age = 0; m_cp = 0;
      for (int i = 0; i < 5; i++) begin
         h1[i] = 1'b0;
         h2[i] = 1'b0;
      end
   endtask

   task automatic score_point(input int who);
      m_mode = MD_POINT;
      m_age  = 0;
      m_cp   = who;
   endtask

   task automatic model_step();
      bit e1, e2, tk;
      for (int i = 4; i > 0; i--) begin
         h1[i] = h1[i-1];
         h2[i] = h2[i-1];
      end
      h1[0] = btn1;
      h2[0] = btn2;
      // a press becomes visible to the referee three clocks after it is sampled
      e1 = h1[3] && !h1[4];
      e2 = h2[3] && !h2[4];
      case (m_mode)
         MD_SERVE: begin
            if ((m_server == 0 && e1) || (m_server == 1 && e2)) begin
               m_mode  = (m_server == 0) ? MD_RIGHT : MD_LEFT;
               m_timer = 0;
            end
         end
         MD_RIGHT: begin
            tk = (m_timer == TD - 1);
            m_timer = tk ? 0 : m_timer + 1;
            if (e2 && m_pos == LL - 1) begin
               m_mode = MD_LEFT; m_timer = 0;
            end else if (e2) score_point(0);
            else if (tk) begin
               if (m_pos == LL - 1) score_point(0);
               else m_pos = m_pos + 1;
            end
         end
         MD_LEFT: begin
            tk = (m_timer == TD - 1);
            m_timer = tk ? 0 : m_timer + 1;
            if (e1 && m_pos == 0) begin
               m_mode = MD_RIGHT; m_timer = 0;
            end else if (e1) score_point(1);
            else if (tk) begin
               if (m_pos == 0) score_point(1);
               else m_pos = m_pos - 1;
            end
         end
         MD_POINT: begin
            if (m_age == GC + 2) begin
               if (finish != 2'd0) m_mode = MD_OVER;
               else begin
                  m_mode   = MD_SERVE;
                  m_server = 1 - m_cp;
                  m_pos    = (m_server == 1) ? LL - 1 : 0;
               end
            end else m_age = m_age + 1;
         end
         default: begin
            if (e1 || e2) begin
               m_mode = MD_SERVE; m_server = 0; m_pos = 0;
            end
         end
      endcase
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge total_reset);
         if (total_reset) model_reset();
         else model_step();
      end
   end

   function automatic logic [LL-1:0] exp_ball();
      logic [LL-1:0] b;
      if (m_mode == MD_OVER) b = '1;
      else b = LL'(1) << m_pos;
      return b;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         check("ball_pos", 32'(ball_pos), 32'(exp_ball()));
         check("serving", 32'(serving), 32'(m_mode == MD_SERVE));
         check("goal", 32'(goal), 32'(m_mode == MD_POINT && m_age >= 1 && m_age <= GC));
         check("current_player", 32'(current_player), m_cp);
      end
   end

   // ---------------- score block: first to 5 points ----------------
   int  sc0, sc1;
   logic prev_goal;
   initial begin
      sc0 = 0; sc1 = 0; prev_goal = 1'b0;
      forever begin
         @(negedge clk or posedge total_reset);
         if (total_reset) begin
            sc0 = 0; sc1 = 0; prev_goal = 1'b0; finish = 2'd0;
         end else begin
            if (goal === 1'b1 && !prev_goal) begin
               if (current_player == 4'd0) sc0++;
               else sc1++;
            end
            prev_goal = (goal === 1'b1);
            finish = (sc0 >= 5) ? 2'd1 : (sc1 >= 5) ? 2'd2 : 2'd0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit p1, input bit p2);
      if (p1) btn1 = 1'b1;
      if (p2) btn2 = 1'b1;
      @(negedge clk);
      if (p1) btn1 = 1'b0;
      if (p2) btn2 = 1'b0;
   endtask

   task automatic wait_pos(input logic [LL-1:0] target, input string name);
      int cyc = 0;
      while (ball_pos !== target && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check(name, 32'(ball_pos), 32'(target));
   endtask

   task automatic wait_goal(input logic [3:0] exp_cp, input string name);
      int cyc = 0;
      while (goal !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_goal"}, 32'(goal), 32'd1);
      check({name, "_cp"}, 32'(current_player), 32'(exp_cp));
      cyc = 0;
      while (goal !== 1'b0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_goal_end"}, 32'(goal), 32'd0);
      step(2);
   endtask

   initial begin
      step(2);
      total_reset = 1'b0;
      check("rst_ball", 32'(ball_pos), 32'h1);
      check("rst_serving", 32'(serving), 32'd1);
      check("rst_goal", 32'(goal), 32'd0);
      check("rst_cp", 32'(current_player), 32'd0);

      // P1 serve, ball crosses, P2 misses
      press(1'b1, 1'b0);
      step(6); check("step_0010", 32'(ball_pos), 32'h2);
      step(6); check("step_1000", 32'(ball_pos), 32'h8);
      step(4); check("miss_goal", 32'(goal), 32'd1);
      check("miss_cp", 32'(current_player), 32'd0);
      step(4); check("p2_serve_wait", 32'(serving), 32'd1);
      check("p2_serve_pos", 32'(ball_pos), 32'h8);

      // non-server press ignored, then a full rally with hits at both ends
      press(1'b1, 1'b0);
      step(4); check("ignore_nonserver", 32'(serving), 32'd1);
      press(1'b0, 1'b1);
      wait_pos(4'b0010, "rally_left");
      press(1'b1, 1'b0);
      wait_pos(4'b0100, "rally_right");
      press(1'b1, 1'b1);
      step(5); check("hit_hold_end", 32'(ball_pos), 32'h8);
      step(1); check("hit_div_restart", 32'(ball_pos), 32'h4);
      wait_goal(4'd1, "p1_miss");

      // foul by P2 mid-lane
      press(1'b1, 1'b0);
      wait_pos(4'b0010, "foul_pos");
      press(1'b0, 1'b1);
      wait_goal(4'd0, "foul");

      // P2 serves and holds the button through the whole rally
      btn2 = 1'b1;
      wait_goal(4'd1, "held_btn2");
      btn2 = 1'b0;

      // hit landing on the final tick at the far end
      press(1'b1, 1'b0);
      wait_pos(4'b0100, "endtick_approach");
      step(2);
      press(1'b0, 1'b1);
      step(3);
      wait_pos(4'b0100, "endtick_return");
      wait_goal(4'd1, "endtick_p1_miss");

      // P1 builds to five points
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      wait_goal(4'd0, "p1_pt3");
      for (int k = 0; k < 2; k++) begin
         press(1'b0, 1'b1);
         wait_pos(4'b0010, "p1_pt_ret");
         press(1'b1, 1'b0);
         press(1'b0, 1'b1);
         wait_goal(4'd0, "p1_pt");
      end
      check("over_ball", 32'(ball_pos), 32'hF);
      check("over_serving", 32'(serving), 32'd0);
      step(5);
      check("over_stays", 32'(ball_pos), 32'hF);
      press(1'b0, 1'b1);
      step(4);
      check("restart_ball", 32'(ball_pos), 32'h1);
      check("restart_serving", 32'(serving), 32'd1);

      // P2 point, then reset in the middle of the goal pulse
      press(1'b1, 1'b0);
      wait_pos(4'b0100, "rst_rally");
      press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      begin
         int cyc = 0;
         while (goal !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
         end
      end
      check("pre_rst_goal", 32'(goal), 32'd1);
      check("pre_rst_cp", 32'(current_player), 32'd1);
      #2 total_reset = 1'b1;
      #1;
      check("async_goal", 32'(goal), 32'd0);
      check("async_ball", 32'(ball_pos), 32'h1);
      check("async_cp", 32'(current_player), 32'd0);
      check("async_serving", 32'(serving), 32'd1);
      step(2);
      total_reset = 1'b0;
      step(3);
      press(1'b1, 1'b0);
      wait_pos(4'b0010, "post_rst_serve");
      step(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

endmodule
